irq_nmi_ctrl: RTL
=================

Name: irq_nmi_ctrl

Overview:
- Interrupt front-end sitting directly upstream of the mos6502 core.
- Synchronises the asynchronous active-low IRQ and NMI pins, edge-detects NMI and level-qualifies IRQ against the core's I flag.
- Sequences the power-on RESET request and arbitrates RES > NMI > IRQ > BRK.
- At each instruction boundary, hands the core one frozen request: type, vector address and pushed-B value, under a req/ack handshake.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the IRQ/NMI synchronisers (legal range 2..4).
- RES_VEC, 16'hFFFC, reset vector address.
- NMI_VEC, 16'hFFFA, NMI vector address.
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector address.

Ports:
- clk  input  1  CPU clock.
- reset  input  1  asynchronous, active-low reset.
- IRQ  input  1  raw interrupt-request pin, active-low, level.
- NMI  input  1  raw non-maskable-interrupt pin, active-low, falling-edge.
- rdy  input  1  core ready; 0 stalls the handshake.
- i_flag  input  1  core I flag; 1 masks IRQ.
- sync  input  1  core is in the opcode-fetch cycle (instruction boundary).
- brk_req  input  1  decoder has a BRK opcode; sampled with sync.
- int_ack  input  1  core has completed the vector fetch; one-cycle pulse.
- int_req  output  1  a request is frozen and awaiting service.
- int_type  output  2  0=RES, 1=NMI, 2=IRQ, 3=BRK.
- vec_addr  output  16  vector address for the frozen int_type.
- b_push  output  1  B bit value for the pushed P (1 only for BRK).
- nmi_pending  output  1  NMI edge latched but not yet serviced (debug/observe).

Behaviour:
- Reset (reset=0) is asynchronous and sets:
  - synchronisers to 1;
  - nmi_latch=0, res_pend=1, state=RES_SEQ;
  - int_req=1, int_type=0, vec_addr=RES_VEC, b_push=0.
- Synchronisers: SYNC_STAGES flops per pin. They always run, independent of rdy.
- NMI edge detector:
  - Sets nmi_latch when the synchronised NMI is 1 in one cycle and 0 in the next. Latency is SYNC_STAGES+1 cycles from the pin to nmi_pending.
  - A held-low NMI produces exactly one event.
  - Edge capture is independent of rdy and of the state.
- IRQ is a level, not latched: irq_live = ~irq_sync & ~i_flag. If IRQ is released before sampling, nothing is taken.
- FSM states: RES_SEQ, IDLE, TAKEN. All transitions are qualified by rdy=1; with rdy=0 the state and outputs hold.
- RES_SEQ:
  - int_req=1, type RES.
  - On int_ack: res_pend=0, int_req=0, go to IDLE.
- IDLE, on sync=1:
  - Pick the highest-priority source among RES, NMI, IRQ, BRK.
  - If one exists, register int_req=1 with type, vec_addr and b_push the following cycle, and go to TAKEN.
  - If none, stay in IDLE.
- TAKEN:
  - Outputs stay frozen regardless of pin changes, including IRQ deasserting or i_flag changing.
  - On int_ack: clear the serviced source (nmi_latch for NMI), int_req=0, go to IDLE.
  - int_ack in IDLE is ignored.
- Simultaneous events:
  - An NMI edge in the same cycle as int_ack for an NMI leaves nmi_latch=1; the set wins over the clear.
  - An NMI edge during an IRQ/BRK service stays pending and is taken at the next sync. There is no hijack.
- BRK with b_push=1 and IRQ both use IRQ_VEC. When both are live at a sync, IRQ wins and b_push=0.
- Reset asserted mid-service aborts immediately and returns to RES_SEQ.

Decomposition:
- Shared package mos6502_pkg holds:
  - the int_type encodings INT_RES, INT_NMI, INT_IRQ, INT_BRK;
  - the vector constants;
  - the FSM state encoding.
- One sub-module is natural: sync_edge_det (parameterised N-flop synchroniser with falling-edge pulse output), instantiated once for NMI and once, with the edge output unused, for IRQ.

Test Plan:
- Power-up: reset low 3 cycles, then high -> int_req=1, int_type=0, vec_addr=FFFC. Pulse int_ack -> int_req=0 next cycle, state IDLE.
- NMI edge: NMI 1->0 with SYNC_STAGES=2:
  - nmi_pending=1 three cycles later.
  - At the next sync -> int_type=1, vec_addr=FFFA, b_push=0.
  - After int_ack, NMI still held low -> no second request.
- IRQ masking:
  - IRQ=0, i_flag=1, sync pulses -> int_req stays 0.
  - Drop i_flag to 0 -> next sync gives int_type=2, vec_addr=FFFE.
  - Release IRQ while TAKEN -> outputs unchanged until int_ack.
- Priority: brk_req=1, IRQ live and NMI edge all pending at one sync -> NMI taken. After int_ack, the next sync -> IRQ (type 2, b_push=0).
- Edge during ack, with rdy stall:
  - rdy=0 while TAKEN and int_ack=1 -> no change.
  - rdy=1 with int_ack and a new NMI edge in the same cycle -> nmi_latch remains 1; the next sync re-takes NMI.
- Mid-service reset: reset asserted while TAKEN with int_type=2 -> immediate int_type=0, vec_addr=FFFC, nmi_latch=0.

Source files
------------

// File: rtl/mos6502_pkg.sv
// Shared encodings for the 6502 interrupt front-end: request types, vectors, FSM states.
// Also holds the fixed RES > NMI > IRQ > BRK priority picker.
package mos6502_pkg;

    typedef enum logic [1:0] {
        INT_RES = 2'd0,
        INT_NMI = 2'd1,
        INT_IRQ = 2'd2,
        INT_BRK = 2'd3
    } int_type_t;

    typedef enum logic [1:0] {
        ST_RES_SEQ = 2'd0,
        ST_IDLE    = 2'd1,
        ST_TAKEN   = 2'd2
    } fsm_state_t;

    localparam logic [15:0] RES_VEC_DFLT = 16'hFFFC;
    localparam logic [15:0] NMI_VEC_DFLT = 16'hFFFA;
    localparam logic [15:0] IRQ_VEC_DFLT = 16'hFFFE;

    // BRK is the fallback: callers only use the result when some source is live.
    function automatic int_type_t pick_source(input logic res, input logic nmi, input logic irq);
        if (res) return INT_RES;
        if (nmi) return INT_NMI;
        if (irq) return INT_IRQ;
        return INT_BRK;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// N-flop synchroniser (resets to 1) with a falling-edge pulse on the synchronised value.
// Latency N cycles to dout, same cycle for fall; free-running, no backpressure.
module sync_edge_det #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic [N-1:0] sync_q;
    logic         prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[N-2:0], din};
            prev_q <= sync_q[N-1];
        end
    end

    assign dout = sync_q[N-1];
    assign fall = prev_q & ~sync_q[N-1];

endmodule

// File: rtl/irq_nmi_ctrl.sv
// 6502 interrupt front-end: syncs IRQ/NMI, arbitrates RES > NMI > IRQ > BRK, freezes one request per boundary.
// Request registered one cycle after sync; rdy=0 holds state and outputs, NMI edge capture keeps running.
module irq_nmi_ctrl
    import mos6502_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] RES_VEC     = RES_VEC_DFLT,
    parameter logic [15:0] NMI_VEC     = NMI_VEC_DFLT,
    parameter logic [15:0] IRQ_VEC     = IRQ_VEC_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IRQ,
    input  logic        NMI,
    input  logic        rdy,
    input  logic        i_flag,
    input  logic        sync,
    input  logic        brk_req,
    input  logic        int_ack,
    output logic        int_req,
    output logic [1:0]  int_type,
    output logic [15:0] vec_addr,
    output logic        b_push,
    output logic        nmi_pending
);

    logic       irq_sync;
    logic       irq_fall_unused;
    logic       nmi_sync;
    logic       nmi_fall;
    logic       irq_live;

    fsm_state_t state_q, state_d;
    int_type_t  type_q, type_d;
    int_type_t  sel;
    logic       res_pend_q, res_pend_d;
    logic       nmi_latch_q;
    logic       nmi_clr;
    logic       int_req_q, int_req_d;
    logic [15:0] vec_q, vec_d;
    logic       b_push_q, b_push_d;
    logic       has_src;

    sync_edge_det #(.N(SYNC_STAGES)) u_nmi_sync (
        .clk   (clk),
        .reset (reset),
        .din   (NMI),
        .dout  (nmi_sync),
        .fall  (nmi_fall)
    );

    sync_edge_det #(.N(SYNC_STAGES)) u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .din   (IRQ),
        .dout  (irq_sync),
        .fall  (irq_fall_unused)
    );

    function automatic logic [15:0] vec_for(input int_type_t t);
        case (t)
            INT_RES: return RES_VEC;
            INT_NMI: return NMI_VEC;
            default: return IRQ_VEC;
        endcase
    endfunction

    // IRQ is a level: it only counts while the pin is low and the core has I clear.
    assign irq_live = ~irq_sync & ~i_flag;
    assign has_src  = res_pend_q | nmi_latch_q | irq_live | brk_req;
    assign sel      = pick_source(res_pend_q, nmi_latch_q, irq_live);

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        vec_d      = vec_q;
        b_push_d   = b_push_q;
        int_req_d  = int_req_q;
        res_pend_d = res_pend_q;
        nmi_clr    = 1'b0;
        if (rdy) begin
            case (state_q)
                ST_RES_SEQ: begin
                    if (int_ack) begin
                        res_pend_d = 1'b0;
                        int_req_d  = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (sync && has_src) begin
                        type_d    = sel;
                        vec_d     = vec_for(sel);
                        b_push_d  = (sel == INT_BRK);
                        int_req_d = 1'b1;
                        state_d   = ST_TAKEN;
                    end
                end
                ST_TAKEN: begin
                    if (int_ack) begin
                        nmi_clr   = (type_q == INT_NMI);
                        if (type_q == INT_RES) begin
                            res_pend_d = 1'b0;
                        end
                        int_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_RES_SEQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RES_SEQ;
            type_q      <= INT_RES;
            vec_q       <= RES_VEC;
            b_push_q    <= 1'b0;
            int_req_q   <= 1'b1;
            res_pend_q  <= 1'b1;
            nmi_latch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            vec_q       <= vec_d;
            b_push_q    <= b_push_d;
            int_req_q   <= int_req_d;
            res_pend_q  <= res_pend_d;
            // A fresh edge in the ack cycle must survive the clear.
            nmi_latch_q <= nmi_fall | (nmi_latch_q & ~nmi_clr);
        end
    end

    assign int_req     = int_req_q;
    assign int_type    = type_q;
    assign vec_addr    = vec_q;
    assign b_push      = b_push_q;
    assign nmi_pending = nmi_latch_q;

endmodule
